// File: rtl/lf8_div.sv
// lf8_div: sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro LF8_DIV_ZERO_CHECK_EN: zero divisor short-circuits to DONE and raises div_zero.
module lf8_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, d, r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   partial, trial;
  logic             borrow;
  logic [WIDTH-1:0] q_shift, r_step;
  logic             accept, finish;

`ifdef LF8_DIV_ZERO_CHECK_EN
  logic zf;
`endif

  // Trial subtraction and next-state decode
  always_comb begin
    state_n = state;
    partial = {r, q[WIDTH-1]};
    trial   = partial - {1'b0, d};
    borrow  = trial[WIDTH];
    r_step  = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    q_shift = {q[WIDTH-2:0], ~borrow};
    accept  = (state == IDLE) && in_valid;
    finish  = (state == BUSY) && (cnt == '0);
    case (state)
      IDLE:    if (in_valid)  state_n = BUSY;
      BUSY:    if (cnt == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  // Working registers; the partial remainder never exceeds the divisor, so WIDTH bits hold it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      d   <= '0;
      r   <= '0;
      cnt <= '0;
`ifdef LF8_DIV_ZERO_CHECK_EN
      zf  <= 1'b0;
`endif
    end else if (accept) begin
      q   <= dividend;
      d   <= divisor;
      r   <= '0;
      cnt <= CW'(WIDTH - 1);
`ifdef LF8_DIV_ZERO_CHECK_EN
      // A single BUSY pass keeps out_valid one cycle after accept
      zf  <= (divisor == '0);
      if (divisor == '0) cnt <= '0;
`endif
    end else if (state == BUSY) begin
      q <= q_shift;
      r <= r_step;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  // Result registers, loaded on the final iteration and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
`ifdef LF8_DIV_ZERO_CHECK_EN
      div_zero  <= 1'b0;
`endif
    end else if (finish) begin
`ifdef LF8_DIV_ZERO_CHECK_EN
      quotient  <= zf ? '1 : q_shift;
      remainder <= zf ? q : r_step;
      div_zero  <= zf;
`else
      quotient  <= q_shift;
      remainder <= r_step;
`endif
    end
  end

`ifndef LF8_DIV_ZERO_CHECK_EN
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_lf8_div.sv
// Scoreboard bench for lf8_div: directed scenarios plus randomized pairs with handshake gaps.
module tb_lf8_div;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_zero;
  logic [W-1:0] quotient, remainder;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  res_t sb[$];

  lf8_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == '0) begin
      m.q = '1;
      m.r = a;
`ifdef LF8_DIV_ZERO_CHECK_EN
      m.dz = 1'b1;
`else
      m.dz = 1'b0;
`endif
    end else begin
      m.q  = a / b;
      m.r  = a % b;
      m.dz = 1'b0;
    end
    return m;
  endfunction

  function automatic int lat_exp(input logic [W-1:0] b);
`ifdef LF8_DIV_ZERO_CHECK_EN
    if (b == '0) return 1;
`endif
    return int'(W);
  endfunction

  // Present a pair until accepted; acc_cyc is the cycle count just after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
    int n;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) $display("FAIL send_ready: in_ready=%0b required 1 within 50 cycles", in_ready);
    else passes++;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    sb.push_back(model(a, b));
  endtask

  // Wait for out_valid, optionally stall, then take the result; lat counts edges from the call
  task automatic get_result(input bit early, input int hold, output res_t got,
                            output int lat, output int hs_cyc);
    out_ready = early;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      $display("FAIL result_timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
      got = 'x;
      hs_cyc = cyc;
      out_ready = 1'b0;
      return;
    end
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    got = {quotient, remainder, div_zero};
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, W'(0), W'(0), 1'b0})
      $display("FAIL reset_state: got rdy=%0b vld=%0b q=%0d r=%0d dz=%0b required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int acc, lat, hs;
    res_t got, exp;
    send(8'd100, 8'd7, acc);
    get_result(1'b0, 0, got, lat, hs);
    checks++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d required 8", lat);
    else passes++;
    exp = sb.pop_front();
    checks++;
    if (got !== exp) $display("FAIL basic_result: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                              got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int acc, acc2, lat, hs;
    res_t got, exp;
    send(8'd255, 8'd1, acc);
    // Next pair is held valid while the first is in flight; it must only be taken from IDLE
    in_valid = 1'b1;
    dividend = 8'd5;
    divisor  = 8'd9;
    get_result(1'b1, 0, got, lat, hs);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) $display("FAIL b2b_first: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                              got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    else passes++;
    send(8'd5, 8'd9, acc2);
    checks++;
    if (acc2 !== hs + 1) $display("FAIL b2b_accept_cycle: got %0d required %0d", acc2, hs + 1);
    else passes++;
    get_result(1'b0, 0, got, lat, hs);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) $display("FAIL b2b_second: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                              got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    else passes++;
  endtask

  task automatic test_div_zero();
    int acc, lat, hs;
    res_t got, exp;
    send(8'd200, 8'd0, acc);
    get_result(1'b0, 0, got, lat, hs);
    checks++;
    if (lat !== lat_exp(8'd0)) $display("FAIL zero_latency: got %0d required %0d", lat, lat_exp(8'd0));
    else passes++;
    exp = sb.pop_front();
    checks++;
    if (got !== exp) $display("FAIL zero_result: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                              got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    else passes++;
  endtask

  task automatic test_backpressure();
    int acc, lat, hs, n;
    res_t got, exp, snap;
    send(8'd77, 8'd10, acc);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    snap = {quotient, remainder, div_zero};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, W'(7), W'(7), 1'b0} ||
          {quotient, remainder, div_zero} !== snap)
        $display("FAIL hold_stall%0d: got vld=%0b rdy=%0b q=%0d r=%0d dz=%0b required 1 0 7 7 0",
                 i, out_valid, in_ready, quotient, remainder, div_zero);
      else passes++;
    end
    get_result(1'b1, 0, got, lat, hs);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) $display("FAIL hold_result: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                              got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    else passes++;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL hold_release: got rdy=%0b vld=%0b required 1 0",
                                                  in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int acc, lat, hs;
    res_t got, exp;
    send(8'd123, 8'd4, acc);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, W'(0), W'(0), 1'b0})
      $display("FAIL midreset_state: got rdy=%0b vld=%0b q=%0d r=%0d dz=%0b required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'd123, 8'd4, acc);
    get_result(1'b0, 0, got, lat, hs);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) $display("FAIL midreset_rerun: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                              got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
    else passes++;
  endtask

  task automatic test_random();
    int acc, lat, hs;
    res_t got, exp;
    logic [W-1:0] a, b;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom);
      send(a, b, acc);
      get_result(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got, lat, hs);
      checks++;
      if (lat !== lat_exp(b)) $display("FAIL rand_latency%0d: got %0d required %0d", i, lat, lat_exp(b));
      else passes++;
      exp = sb.pop_front();
      checks++;
      if (got !== exp)
        $display("FAIL rand_result%0d %0d/%0d: got q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                 i, a, b, got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
      else passes++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL drain: got pending=%0d vld=%0b required 0 0", sb.size(), out_valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
